accumulator_io_bridge: RTL
==========================

# accumulator_io_bridge

Bidirectional I/O bridge between the accumulator core's `IOIn`/`Output` buses and the external world. External producers push words through a valid/ready stream into a small input FIFO, and the FIFO head drives the core's `IOIn`. Words the core writes on `Output` are captured into a one-entry holding register and offered downstream on a valid/ready stream. The block sits at the top level beside `accumulatorFull`, replacing direct bench or pin drive of `IOIn`.

## Interface
Parameters:
- `WIDTH`, 16, data width of every data bus
- `IN_DEPTH`, 4, input FIFO entries; power of two, ≥2

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `ext_in_data`  in  WIDTH  external input word
- `ext_in_valid`  in  1  external input word present
- `ext_in_ready`  out  1  FIFO can accept a word
- `IOIn`  out  WIDTH  FIFO head to the core; 0 when the FIFO is empty
- `core_in_empty`  out  1  FIFO empty; the core stalls on an input instruction
- `core_in_rd`  in  1  core consumed `IOIn` this cycle (pop)
- `core_Output`  in  WIDTH  core output bus
- `core_out_wr`  in  1  core output-instruction strobe
- `core_out_full`  out  1  holding register cannot accept a write this cycle
- `ext_out_data`  out  WIDTH  held output word
- `ext_out_valid`  out  1  held word valid
- `ext_out_ready`  in  1  downstream accepts the word

## Operation
- Reset values: FIFO empty, `ext_in_ready`=1, `IOIn`=0, `core_in_empty`=1, `ext_out_valid`=0, `ext_out_data`=0, `core_out_full`=0, pointers and count cleared. Reset always wins over every same-cycle event and discards words in flight.
- Input push: occurs when `ext_in_valid && ext_in_ready`.
- `ext_in_ready` = !full, taken from registered count only. A same-cycle pop does not free a slot while the FIFO is full.
- Input pop: occurs when `core_in_rd && !core_in_empty`.
  - Pop on empty is ignored, with no pointer or count change.
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.
- Pointers are `log2(IN_DEPTH)` bits and wrap modulo `IN_DEPTH`. Count is `log2(IN_DEPTH)+1` bits.
- Output holding register uses a two-state FSM:
  - OUT_EMPTY: on `core_out_wr`, latch `core_Output` and go to OUT_HOLD.
  - OUT_HOLD: `ext_out_valid`=1.
    - On `ext_out_ready` without `core_out_wr`, go to OUT_EMPTY.
    - On `ext_out_ready && core_out_wr`, reload the new word and stay in OUT_HOLD.
    - On `core_out_wr` without `ext_out_ready`, drop the write; register and state are unchanged.
- `core_out_full` = OUT_HOLD && !`ext_out_ready` (combinational).
- `ext_out_data` holds its value while in OUT_EMPTY.

## Timing
- Push to `IOIn` visible: 1 cycle. A word accepted at edge N appears on `IOIn` after edge N, and `core_in_empty` falls in the same cycle.
- Pop: the next head appears after the popping edge.
- `core_out_wr` to `ext_out_valid`: 1 cycle.
- Back-to-back output words: one word per cycle while `ext_out_ready` is held high.
- `IOIn` is read combinationally from FIFO storage at the read pointer. There is no combinational path from `core_in_rd` to `IOIn`.

## Configuration
- `IO_BRIDGE_STATS_EN` defined: adds outputs `in_underrun_cnt` and `out_drop_cnt`, each 8-bit and saturating at 8'hFF, both reset to 0.
  - `in_underrun_cnt` increments on `core_in_rd` while empty.
  - `out_drop_cnt` increments on a dropped `core_out_wr`.
- Not defined: the ports and counters are absent, and the events are silently ignored.

## Structure
- Package `io_bridge_pkg`: default `WIDTH`, default `IN_DEPTH`, output FSM state typedef (OUT_EMPTY=0, OUT_HOLD=1), stats counter width constant (8).
- Sub-module `io_bridge_fifo`: synchronous FIFO holding the storage array, pointers and count. Exposes push, pop, head, full and empty.
- The output FSM and the stats counters live in the top module.

## Test plan
- Reset, then check idle values: hold `reset` for 3 cycles with `ext_in_data`=16'hff00, `ext_in_valid`=1.
  - Required: `IOIn`=0, `core_in_empty`=1, `ext_out_valid`=0 throughout reset.
  - Required: 16'hff00 appears on `IOIn` one cycle after reset release.
- FIFO ordering and full:
  - Push 16'h0001 through 16'h0005 back-to-back with no pops.
  - Required: `ext_in_ready` falls after the 4th accept; the 5th word is held.
  - Pop four times; required `IOIn` sequence is 0001, 0002, 0003, 0004, then 0005 after the slot frees.
- Simultaneous push and pop at count 2: count stays 2, order is preserved, and pointers wrap past `IN_DEPTH`-1 without corruption.
- Output back-pressure:
  - `core_out_wr` with 16'h1234 while `ext_out_ready`=0.
  - Required: `ext_out_valid`=1 next cycle, `core_out_full`=1.
  - A second write of 16'h5678 is dropped; `ext_out_data` stays 16'h1234.
- Output drain-and-reload: in OUT_HOLD, assert `ext_out_ready` and `core_out_wr` with 16'hABCD in the same cycle. Required: `ext_out_valid` stays 1 and `ext_out_data`=16'hABCD.
- Stats (`IO_BRIDGE_STATS_EN` defined):
  - 300 pops on empty give `in_underrun_cnt`=8'hFF (saturated).
  - One dropped write gives `out_drop_cnt`=1.
  - Mid-run `reset` clears both counters to 0.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared constants, output FSM state type and saturating-counter helper for the
// accumulator I/O bridge. Optional statistics are enabled by IO_BRIDGE_STATS_EN.
package io_bridge_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int IN_DEPTH_DEF = 4;
  localparam int STATS_W      = 8;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_e;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    if (v == {STATS_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(STATS_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/io_bridge_if.sv
// Bus bundle between the accumulator core, the external streams and the bridge.
// The bridge takes the slave view; the surrounding environment takes master.
interface io_bridge_if
  import io_bridge_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] ext_in_data;
  logic             ext_in_valid;
  logic             ext_in_ready;
  logic [WIDTH-1:0] IOIn;
  logic             core_in_empty;
  logic             core_in_rd;
  logic [WIDTH-1:0] core_Output;
  logic             core_out_wr;
  logic             core_out_full;
  logic [WIDTH-1:0] ext_out_data;
  logic             ext_out_valid;
  logic             ext_out_ready;

  modport slave (
    input  ext_in_data, ext_in_valid, core_in_rd, core_Output, core_out_wr, ext_out_ready,
    output ext_in_ready, IOIn, core_in_empty, core_out_full, ext_out_data, ext_out_valid
  );

  modport master (
    output ext_in_data, ext_in_valid, core_in_rd, core_Output, core_out_wr, ext_out_ready,
    input  ext_in_ready, IOIn, core_in_empty, core_out_full, ext_out_data, ext_out_valid
  );

endinterface

// File: rtl/io_bridge_fifo.sv
// Synchronous input FIFO: storage, wrapping pointers and occupancy count.
// Full/empty come from the registered count only, so a pop never frees a slot same-cycle.
module io_bridge_fifo
  import io_bridge_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int IN_DEPTH = IN_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(IN_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IN_DEPTH);

  logic [WIDTH-1:0] r_mem [IN_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == DEPTH_CNT);
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      for (int i = 0; i < IN_DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/accumulator_io_bridge.sv
// Bridges the accumulator core's IOIn/Output buses to external valid/ready streams.
// Define IO_BRIDGE_STATS_EN to add saturating underrun and dropped-write counters.
module accumulator_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int IN_DEPTH = IN_DEPTH_DEF
) (
  input  logic               CLK,
  input  logic               reset,
  io_bridge_if.slave         bus
`ifdef IO_BRIDGE_STATS_EN
  ,
  output logic [STATS_W-1:0] in_underrun_cnt,
  output logic [STATS_W-1:0] out_drop_cnt
`endif
);

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [WIDTH-1:0] w_fifo_head;
  out_state_e       r_out_state;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  io_bridge_fifo #(
    .WIDTH    (WIDTH),
    .IN_DEPTH (IN_DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .reset       (reset),
    .i_push      (bus.ext_in_valid),
    .i_push_data (bus.ext_in_data),
    .i_pop       (bus.core_in_rd),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign bus.ext_in_ready  = !w_fifo_full;
  assign bus.core_in_empty = w_fifo_empty;
  assign bus.IOIn          = w_fifo_empty ? {WIDTH{1'b0}} : w_fifo_head;

  // Core may write only when the holding register is empty or is being drained this cycle.
  assign bus.core_out_full = (r_out_state == OUT_HOLD) && !bus.ext_out_ready;
  assign bus.ext_out_valid = r_out_valid;
  assign bus.ext_out_data  = r_out_data;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_out_state <= OUT_EMPTY;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else begin
      case (r_out_state)
        OUT_EMPTY: begin
          if (bus.core_out_wr) begin
            r_out_data  <= bus.core_Output;
            r_out_state <= OUT_HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_out_data  <= r_out_data;
            r_out_state <= OUT_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        OUT_HOLD: begin
          if (bus.ext_out_ready && bus.core_out_wr) begin
            r_out_data  <= bus.core_Output;
            r_out_state <= OUT_HOLD;
            r_out_valid <= 1'b1;
          end else if (bus.ext_out_ready) begin
            r_out_data  <= r_out_data;
            r_out_state <= OUT_EMPTY;
            r_out_valid <= 1'b0;
          end else begin
            r_out_data  <= r_out_data;
            r_out_state <= OUT_HOLD;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_data  <= r_out_data;
          r_out_state <= OUT_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IO_BRIDGE_STATS_EN
  logic               w_in_underrun;
  logic               w_out_drop;
  logic [STATS_W-1:0] r_in_underrun_cnt;
  logic [STATS_W-1:0] r_out_drop_cnt;

  assign w_in_underrun   = bus.core_in_rd && w_fifo_empty;
  assign w_out_drop      = bus.core_out_wr && (r_out_state == OUT_HOLD) && !bus.ext_out_ready;
  assign in_underrun_cnt = r_in_underrun_cnt;
  assign out_drop_cnt    = r_out_drop_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_in_underrun_cnt <= {STATS_W{1'b0}};
      r_out_drop_cnt    <= {STATS_W{1'b0}};
    end else begin
      r_in_underrun_cnt <= w_in_underrun ? sat_inc(r_in_underrun_cnt) : r_in_underrun_cnt;
      r_out_drop_cnt    <= w_out_drop ? sat_inc(r_out_drop_cnt) : r_out_drop_cnt;
    end
  end
`endif

endmodule
